// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
// Group generate/propagate reduction and the WIDTH divisibility check live here.
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef struct packed {
    logic gg;
    logic gp;
  } grp_gp_t;

  // Collapse per-bit generate/propagate of one 4-bit group into group GG/GP.
  function automatic grp_gp_t group_gp(input logic [GROUP_W-1:0] g,
                                       input logic [GROUP_W-1:0] p);
    grp_gp_t r;
    r.gp = &p;
    r.gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return r;
  endfunction

  function automatic bit width_ok(input int width, input int groups_per_stage);
    return (groups_per_stage > 0) && (width > 0) &&
           ((width % (GROUP_W * groups_per_stage)) == 0);
  endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group: slice sum plus group generate/propagate.
module cla_group4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] sum,
  output logic               gg,
  output logic               gp
);

  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] c;
  grp_gp_t            ggp;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    sum  = p ^ c;
    ggp  = group_gp(g, p);
    gg   = ggp.gg;
    gp   = ggp.gp;
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one slice of GROUPS_PER_STAGE groups per stage.
// Optional CLA_PIPE_FLAGS_EN adds registered signed-overflow and zero flags.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int GROUPS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
`ifdef CLA_PIPE_FLAGS_EN
  output logic             out_ovf,
  output logic             out_zero,
`endif
  output logic             out_cout
);

  localparam int SLICE_W  = GROUP_W * GROUPS_PER_STAGE;
  localparam int STAGES   = WIDTH / SLICE_W;
  localparam int OP_DEPTH = (STAGES > 1) ? STAGES - 1 : 1;

  if (!width_ok(WIDTH, GROUPS_PER_STAGE)) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a multiple of 4*GROUPS_PER_STAGE");
  end

  // Handshake: a beat moves on an edge where valid & ready are both high. The whole
  // pipe advances together (adv), so in_ready is simply "output slot free or draining".
  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv;
    b_eff    = in_sub ? ~in_b : in_b;
    c_eff    = in_sub ? 1'b1 : in_cin;
  end

  logic             vld_d [STAGES];
  logic             vld_q [STAGES];
  logic             cy_d  [STAGES];
  logic             cy_q  [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic [WIDTH-1:0] a_d   [OP_DEPTH];
  logic [WIDTH-1:0] a_q   [OP_DEPTH];
  logic [WIDTH-1:0] b_d   [OP_DEPTH];
  logic [WIDTH-1:0] b_q   [OP_DEPTH];

`ifdef CLA_PIPE_FLAGS_EN
  logic ovf_d;
  logic ovf_q;
  logic zero_d;
  logic zero_q;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0]            a_src;
    logic [WIDTH-1:0]            b_src;
    logic [WIDTH-1:0]            s_src;
    logic                        c_src;
    logic                        v_src;
    logic [GROUPS_PER_STAGE-1:0] gg;
    logic [GROUPS_PER_STAGE-1:0] gp;
    logic [GROUPS_PER_STAGE:0]   gc;
    logic                        c_run;
    logic [SLICE_W-1:0]          slice_sum;
    logic [WIDTH-1:0]            s_nxt;

    if (k == 0) begin : g_head
      assign a_src = in_a;
      assign b_src = b_eff;
      assign s_src = '0;
      assign c_src = c_eff;
      assign v_src = in_valid;
    end else begin : g_tail
      assign a_src = a_q[k-1];
      assign b_src = b_q[k-1];
      assign s_src = s_q[k-1];
      assign c_src = cy_q[k-1];
      assign v_src = vld_q[k-1];
    end

    for (genvar j = 0; j < GROUPS_PER_STAGE; j++) begin : g_grp
      cla_group4 u_grp (
        .a   (a_src[k*SLICE_W + j*GROUP_W +: GROUP_W]),
        .b   (b_src[k*SLICE_W + j*GROUP_W +: GROUP_W]),
        .cin (gc[j]),
        .sum (slice_sum[j*GROUP_W +: GROUP_W]),
        .gg  (gg[j]),
        .gp  (gp[j])
      );
    end

    // Group carries come only from GG/GP and the stage carry-in, never from group sums.
    always_comb begin
      c_run = c_src;
      gc    = '0;
      gc[0] = c_src;
      for (int j = 0; j < GROUPS_PER_STAGE; j++) begin
        c_run   = gg[j] | (gp[j] & c_run);
        gc[j+1] = c_run;
      end
    end

    always_comb begin
      s_nxt                       = s_src;
      s_nxt[k*SLICE_W +: SLICE_W] = slice_sum;
    end

    assign vld_d[k] = v_src;
    assign cy_d[k]  = gc[GROUPS_PER_STAGE];
    assign s_d[k]   = s_nxt;

    if (k < STAGES - 1) begin : g_ops
      assign a_d[k] = a_src;
      assign b_d[k] = b_src;
    end

`ifdef CLA_PIPE_FLAGS_EN
    if (k == STAGES - 1) begin : g_last
      assign ovf_d  = (a_src[WIDTH-1] == b_src[WIDTH-1]) && (s_nxt[WIDTH-1] != a_src[WIDTH-1]);
      assign zero_d = ~|s_nxt;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        cy_q[k]  <= 1'b0;
        s_q[k]   <= '0;
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_d[k];
        cy_q[k]  <= cy_d[k];
        s_q[k]   <= s_d[k];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
      end
    end
  end

`ifdef CLA_PIPE_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_ovf  = ovf_q;
  assign out_zero = zero_q;
`endif

  assign out_valid = vld_q[STAGES-1];
  assign out_sum   = s_q[STAGES-1];
  assign out_cout  = cy_q[STAGES-1];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder (WIDTH=32, GROUPS_PER_STAGE=2, four stages).
// Flag checks are active when CLA_PIPE_FLAGS_EN is defined.
module tb_cla_pipe_adder;

  localparam int WIDTH  = 32;
  localparam int GPS    = 2;
  localparam int STAGES = WIDTH / (4 * GPS);
  localparam int EW     = WIDTH + 3;
`ifdef CLA_PIPE_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
`ifdef CLA_PIPE_FLAGS_EN
  logic             out_ovf;
  logic             out_zero;
`endif

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;
  int bp_idx   = 0;
  int out_base = 0;
  bit acc;
  logic [WIDTH-1:0] held_sum;
  logic             held_cout;
  logic [EW-1:0]    exp_q[$];

  cla_pipe_adder #(.WIDTH(WIDTH), .GROUPS_PER_STAGE(GPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
`ifdef CLA_PIPE_FLAGS_EN
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
`endif
    .out_cout  (out_cout)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain wide addition on the effective operands.
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic cin, input logic sub);
    logic [WIDTH-1:0] be;
    logic             ce;
    logic [WIDTH:0]   full;
    logic             ovf;
    logic             zero;
    be   = sub ? ~b : b;
    ce   = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, be} + {{WIDTH{1'b0}}, ce};
    ovf  = (a[WIDTH-1] == be[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    zero = (full[WIDTH-1:0] == '0);
    return {ovf & FLAGS, zero & FLAGS, full};
  endfunction

  function automatic logic [EW-1:0] hw(input logic [WIDTH-1:0] s, input logic c,
                                       input logic o, input logic z);
    return {o & FLAGS, z & FLAGS, c, s};
  endfunction

  function automatic logic [EW-1:0] observed();
    logic o;
    logic z;
    o = 1'b0;
    z = 1'b0;
`ifdef CLA_PIPE_FLAGS_EN
    o = out_ovf;
    z = out_zero;
`endif
    return {o, z, out_cout, out_sum};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Driver + scoreboard step: record handshakes at the negedge, then advance one edge.
  task automatic tick(output bit accepted);
    @(negedge clk);
    accepted = in_valid && in_ready;
    if (accepted) exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
      else chk("stream_out", 64'(observed()), 64'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  // One isolated beat through an empty pipe, with exact latency and hand-computed result.
  task automatic send_one(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sub, input logic [WIDTH-1:0] s,
                          input logic c, input logic o, input logic z);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (STAGES - 2) @(posedge clk);
    #1;
    chk({tag, "_early"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_result"}, 64'(observed()), 64'(hw(s, c, o, z)));
    @(posedge clk);
    #1;
    chk({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  task automatic set_bp(input int idx);
    in_a   = 32'h0F0F_0F0F + 32'(idx) * 32'h1111_1111;
    in_b   = 32'hF0F0_F0F0 - 32'(idx);
    in_cin = 1'b1;
    in_sub = idx[0];
  endtask

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_word", 64'(observed()), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed single beats
    send_one("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    send_one("sub_5_7",    32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    send_one("sub_7_5",    32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    send_one("ovf_pos",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send_one("ovf_neg",    32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
    send_one("add_cin",    32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0);
    send_one("sub_cin_ig", 32'h0000_000A, 32'h0000_000A, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    send_one("stage_cross", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);

    // Back-to-back throughput
    n_out = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_a     = $urandom;
      in_b     = $urandom;
      in_cin   = 1'($urandom_range(0, 1));
      in_sub   = 1'($urandom_range(0, 1));
      tick(acc);
      chk("stream_accept", 64'(acc), 64'd1);
    end
    in_valid = 1'b0;
    chk("stream_fill", 64'(n_out), 64'(100 - STAGES));
    repeat (STAGES) tick(acc);
    chk("stream_count", 64'(n_out), 64'd100);
    chk("stream_q_empty", 64'(exp_q.size()), 64'd0);
    tick(acc);

    // Backpressure: 6 stalled cycles with 5 beats on offer
    out_base  = n_out;
    bp_idx    = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (bp_idx < 5);
      set_bp(bp_idx);
      tick(acc);
      if (acc) bp_idx++;
    end
    chk("bp_accepted", 64'(bp_idx), 64'd4);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_head", 64'(observed()), 64'(exp_q[0]));
    held_sum  = out_sum;
    held_cout = out_cout;
    for (int c = 0; c < 2; c++) begin
      tick(acc);
      chk("bp_hold_sum", 64'(out_sum), 64'(held_sum));
      chk("bp_hold_cout", 64'(out_cout), 64'(held_cout));
      chk("bp_hold_no_accept", 64'(acc), 64'd0);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && !(bp_idx == 5 && exp_q.size() == 0); c++) begin
      in_valid = (bp_idx < 5);
      set_bp((bp_idx < 5) ? bp_idx : 4);
      tick(acc);
      if (acc) bp_idx++;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", 64'(bp_idx), 64'd5);
    chk("bp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("bp_out_count", 64'(n_out - out_base), 64'd5);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Async reset with beats in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a     = 32'h0000_0100 * 32'(i + 1);
      in_b     = 32'h0000_0011;
      in_cin   = 1'b0;
      in_sub   = 1'b0;
      tick(acc);
      chk("rst_flight_accept", 64'(acc), 64'd1);
    end
    in_valid = 1'b0;
    tick(acc);
    chk("rst_head_valid", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_word", 64'(observed()), 64'd0);
    chk("rst_async_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_base = n_out;
    repeat (6) tick(acc);
    chk("rst_no_stale", 64'(n_out - out_base), 64'd0);
    send_one("rst_after", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
